// File: rtl/sfx_scheduler_if.sv
// Engine-side bundle for the sound-effect scheduler: request pulses in,
// grant/status and square-wave tone controls out.
interface sfx_scheduler_if;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        busy;
    logic        music_mute;
    logic        tone_en;
    logic [17:0] tone_period;
    logic        done;

    modport master (
        output req,
        input  grant, busy, music_mute, tone_en, tone_period, done
    );

    modport slave (
        input  req,
        output grant, busy, music_mute, tone_en, tone_period, done
    );
endinterface

// File: rtl/sfx_scheduler.sv
// Fixed-priority sound-effect scheduler: latches engine requests, plays the
// granted effect's note list from ROM and mutes background music meanwhile.
module sfx_scheduler #(
    parameter int TICK_DIV  = 100000,
    parameter int GAP_TICKS = 10
) (
    input logic             clk,
    input logic             dreset,
    sfx_scheduler_if.slave  bus
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TK_W  = 16;

    typedef enum logic [2:0] {IDLE, LOAD, NOTE, GAP, DONE} state_t;

    state_t            state, state_d;
    logic [3:0]        pending, grant_q, pick, above;
    logic [CNT_W-1:0]  cnt;
    logic [TK_W-1:0]   tk;
    logic [1:0]        idx, eff, next_idx;
    logic [25:0]       cur_rom, next_rom;
    logic              preempt, tick_end, note_end, gap_end, last_note, enter;
    logic              busy_q, done_q, tone_en_q;
    logic [17:0]       tone_period_q;

    function automatic logic [3:0] top_bit(input logic [3:0] v);
        casez (v)
            4'b1???: top_bit = 4'b1000;
            4'b01??: top_bit = 4'b0100;
            4'b001?: top_bit = 4'b0010;
            4'b0001: top_bit = 4'b0001;
            default: top_bit = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] higher_mask(input logic [3:0] g);
        case (g)
            4'b0001: higher_mask = 4'b1110;
            4'b0010: higher_mask = 4'b1100;
            4'b0100: higher_mask = 4'b1000;
            default: higher_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
    endfunction

    // {half_period[17:0], ticks[7:0]} per effect/note
    function automatic logic [25:0] rom(input logic [1:0] e, input logic [1:0] i);
        case ({e, i})
            4'b00_00: rom = {18'd113636, 8'd30};
            4'b01_00: rom = {18'd95602,  8'd40};
            4'b01_01: rom = {18'd63776,  8'd40};
            4'b10_00: rom = {18'd95602,  8'd80};
            4'b10_01: rom = {18'd75872,  8'd80};
            4'b10_10: rom = {18'd63776,  8'd80};
            4'b10_11: rom = {18'd47755,  8'd160};
            4'b11_00: rom = {18'd127551, 8'd100};
            4'b11_01: rom = {18'd151515, 8'd100};
            4'b11_10: rom = {18'd190839, 8'd200};
            default:  rom = {18'd0,      8'd1};
        endcase
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] e);
        case (e)
            2'd0:    last_idx = 2'd0;
            2'd1:    last_idx = 2'd1;
            2'd2:    last_idx = 2'd3;
            default: last_idx = 2'd2;
        endcase
    endfunction

    assign pick      = top_bit(pending);
    assign above     = higher_mask(grant_q);
    assign eff       = enc(grant_q);
    assign cur_rom   = rom(eff, idx);
    assign next_idx  = (state == GAP) ? idx + 2'd1 : 2'd0;
    assign next_rom  = rom(eff, next_idx);
    assign last_note = (idx == last_idx(eff));
    assign tick_end  = (cnt == CNT_W'(TICK_DIV - 1));
    assign note_end  = tick_end && (tk == {8'd0, cur_rom[7:0]} - TK_W'(1));
    assign gap_end   = tick_end && (tk == TK_W'(GAP_TICKS - 1));
    // Preemption looks at latched requests so it lands one edge after the pulse.
    assign preempt   = ((state == LOAD) || (state == NOTE) || (state == GAP)) &&
                       (|(pending & above));

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (|pending) state_d = LOAD;
            LOAD: state_d = preempt ? LOAD : NOTE;
            NOTE: begin
                if (preempt)       state_d = LOAD;
                else if (note_end) state_d = last_note ? DONE : GAP;
            end
            GAP: begin
                if (preempt)      state_d = LOAD;
                else if (gap_end) state_d = NOTE;
            end
            DONE:    state_d = (|pending) ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter = (state_d != state) || preempt;

    always_ff @(posedge clk or negedge dreset) begin
        if (!dreset) begin
            state         <= IDLE;
            pending       <= '0;
            grant_q       <= '0;
            cnt           <= '0;
            tk            <= '0;
            idx           <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tone_en_q     <= 1'b0;
            tone_period_q <= '0;
        end else begin
            state     <= state_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            tone_en_q <= (state_d == NOTE);

            // Prescaler restarts on every state entry so durations are exact.
            if (enter) begin
                cnt <= '0;
                tk  <= '0;
            end else if (tick_end) begin
                cnt <= '0;
                tk  <= tk + TK_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if ((state_d == LOAD) && enter) begin
                grant_q <= pick;
                pending <= (pending & ~pick) | bus.req;
                idx     <= 2'd0;
            end else begin
                pending <= pending | bus.req;
                if ((state_d == DONE) || (state_d == IDLE)) grant_q <= '0;
            end

            if ((state_d == NOTE) && enter) begin
                tone_period_q <= next_rom[25:8];
                idx           <= next_idx;
            end else if (state_d != NOTE) begin
                tone_period_q <= '0;
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.music_mute  = busy_q;
    assign bus.tone_en     = tone_en_q;
    assign bus.tone_period = tone_period_q;
    assign bus.done        = done_q;
endmodule

// File: doc/sfx_scheduler.md
# sfx_scheduler

Sound-effect scheduler that sits between the game engine's event pulses and the square-wave tone output. It arbitrates four one-cycle effect requests by fixed priority and latches requests that arrive while busy. It sequences the granted effect's fixed note list (pitch, duration, inter-note gap) from an internal ROM. It also mutes the background song player while an effect plays.

## Interface
Parameters:
- TICK_DIV, 100000: clk cycles per duration tick (1 ms at 100 MHz); benches use 10.
- GAP_TICKS, 10: silent ticks between consecutive notes of one effect.

Ports:
- clk  in  1  system clock; all state on rising edge.
- dreset  in  1  asynchronous, active-low reset.
- req  in  4  one-cycle request pulses from the game engine; bit0 move, bit1 select, bit2 win, bit3 lose; bit3 has highest priority.
- grant  out  4  one-hot; the effect currently playing; 0 when idle.
- busy  out  1  high in every state except IDLE.
- music_mute  out  1  equals busy; gates the song player output.
- tone_en  out  1  high only while a note sounds.
- tone_period  out  18  tone half-period in clk cycles; valid while tone_en=1, 0 otherwise.
- done  out  1  one-cycle pulse when an effect completes normally.

## Operation
- Effect ROM entries are listed as half-period/ticks, in order:
  - move: 113636/30.
  - select: 95602/40, then 63776/40.
  - win: 95602/80, 75872/80, 63776/80, then 47755/160.
  - lose: 127551/100, 151515/100, then 190839/200.
- pending[3:0] is sticky. pending |= req every cycle. A bit clears on the cycle its effect is granted.
- FSM states: IDLE, LOAD, NOTE, GAP, DONE.
  - IDLE: if pending≠0, go to LOAD.
  - LOAD: grant ← highest set pending bit; clear that bit; note index ← 0; go to NOTE.
  - NOTE: tone_en=1 and tone_period=ROM[grant][idx]. Hold for exactly ticks×TICK_DIV cycles.
    - If this is the last note, go to DONE.
    - Otherwise go to GAP.
  - GAP: tone_en=0. Hold for GAP_TICKS×TICK_DIV cycles, then idx+1 and go to NOTE.
  - DONE: done=1 for one cycle and grant←0.
    - Go to LOAD if pending≠0.
    - Otherwise go to IDLE.
- Preemption: a req bit of strictly higher priority than the current grant, seen in LOAD/NOTE/GAP, forces the next state to LOAD. That request is granted in LOAD. The interrupted effect is discarded, is not resumed, and gets no done pulse.
- A request of equal or lower priority while busy is only latched. It plays later, once, however many pulses arrived.
- Simultaneous requests: the highest bit is granted; the others stay pending and play in priority order afterwards.
- Tick counter: free-running prescaler reset to 0 on every state entry, so durations are exact cycle counts.

## Timing
- Reset (dreset=0) takes effect immediately, including mid-effect. It sets state=IDLE and zeroes pending, grant, busy, music_mute, tone_en, tone_period, done, and all counters.
- Request pulse in cycle k, from IDLE:
  - pending is set at edge k.
  - LOAD at edge k+1; grant and busy high from here.
  - NOTE at edge k+2: tone_en high, so latency is 2 cycles.
- Note length is exactly ticks×TICK_DIV cycles of tone_en=1. Gap length is exactly GAP_TICKS×TICK_DIV cycles of tone_en=0.
- DONE lasts one cycle. If pending≠0, the next effect's tone_en rises 2 cycles after DONE, with no IDLE cycle between.
- Preemption:
  - Higher request at cycle p → LOAD at edge p+1 → new NOTE at edge p+2.
  - tone_en drops during the LOAD cycle.
- tone_period changes only on NOTE entry.
- Outputs are registered; no combinational path from req to any output.

## Test plan
Use TICK_DIV=10 and GAP_TICKS=10.
- **Reset:** hold dreset=0 with req pulsing → all outputs 0. Release → still idle, busy=0.
- **Single move:** req=0001 pulse at cycle k → grant=0001 at k+1; tone_en=1 with tone_period=113636 for exactly 300 cycles. Then one done pulse, then busy=0.
- **Select sequence:** req=0010 → 400 cycles of 95602, 100 silent cycles, 400 cycles of 63776, then done.
- **Simultaneous requests:** req=0101 in one cycle → win plays fully (95602/75872/63776/47755) → done → move plays 2 cycles later → done → idle. Exactly two done pulses.
- **Preemption:** start move; at cycle 50 of its note pulse req=1000 → LOAD next cycle, grant=1000, tone_period=127551 two cycles after the pulse. No done pulse for move, and move does not resume.
- **Latching and mid-effect reset:** during lose, pulse req=0001 three times → after lose, move plays exactly once. Repeat and assert dreset=0 mid-note → tone_en and music_mute drop immediately, and nothing plays after release.
